// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: classifies the RV opcode, builds the sign-extended
// immediate and queues {instr, imm, fmt} in a small in-order FIFO toward execute.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [15:0]     illegal_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     illegal_cnt_q, illegal_cnt_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     instr_mem_d [DEPTH];
    logic [XLEN-1:0] imm_mem_q [DEPTH];
    logic [XLEN-1:0] imm_mem_d [DEPTH];
    logic [2:0]      fmt_mem_q [DEPTH];
    logic [2:0]      fmt_mem_d [DEPTH];

    logic            push, pop;
    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm;
    logic [XLEN-1:0] dec_imm_ext;

    // Every format is first built as a 32-bit sign-extended value, then widened to XLEN.
    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FMT_I;
                dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = {in_instr[31:12], 12'h000};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: begin
                dec_fmt = FMT_R;
            end
            default: ;
        endcase
        dec_imm_ext = XLEN'($signed(dec_imm));
    end

    // in_ready comes from count_q only, so a full buffer never admits on a same-cycle pop.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        illegal_cnt_d = illegal_cnt_q;
        instr_mem_d   = instr_mem_q;
        imm_mem_d     = imm_mem_q;
        fmt_mem_d     = fmt_mem_q;
        if (push) begin
            instr_mem_d[wr_ptr_q] = in_instr;
            imm_mem_d[wr_ptr_q]   = dec_imm_ext;
            fmt_mem_d[wr_ptr_q]   = dec_fmt;
            wr_ptr_d              = wr_ptr_q + PW'(1);
            if (dec_fmt == FMT_ILL && illegal_cnt_q != 16'hFFFF) begin
                illegal_cnt_d = illegal_cnt_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            illegal_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Entry payload needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        imm_mem_q   <= imm_mem_d;
        fmt_mem_q   <= fmt_mem_d;
    end

    always_comb begin
        out_instr   = '0;
        out_imm     = '0;
        out_fmt     = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_instr   = instr_mem_q[rd_ptr_q];
            out_imm     = imm_mem_q[rd_ptr_q];
            out_fmt     = fmt_mem_q[rd_ptr_q];
            out_illegal = (fmt_mem_q[rd_ptr_q] == FMT_ILL);
        end
    end

    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, buffered immediate generator for the decode stage. Accepts 32-bit RV32I/RV64I instructions over a valid/ready handshake, fully decodes the opcode into one of the R/I/S/B/U/J formats and produces the sign-extended XLEN-bit immediate. Results pass through a small in-order FIFO so fetch and execute can stall independently. A saturating counter tracks illegal opcodes.

## Interface
- XLEN, 32, immediate output width; legal values 32 or 64
- DEPTH, 2, buffer entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction on in_instr is valid
- in_instr  in  32  raw instruction word
- in_ready  out  1  block can accept an instruction this cycle
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes the head entry this cycle
- out_instr  out  32  instruction word of the head entry
- out_imm  out  XLEN  sign-extended immediate of the head entry
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7
- out_illegal  out  1  head opcode is not recognised
- illegal_cnt  out  16  saturating count of accepted illegal instructions

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready. Push and pop in the same cycle both take effect; count is unchanged.
- Decode happens before the write, on in_instr[6:0]:
  - 0000011, 0010011, 0011011, 1100111, 1110011 -> I: instr[31:20]
  - 0100011 -> S: {instr[31:25], instr[11:7]}
  - 1100011 -> B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - 0110111, 0010111 -> U: {instr[31:12], 12'b0}
  - 1101111 -> J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - 0110011, 0111011 -> R: imm = 0
  - anything else -> fmt 7, illegal = 1, imm = 0
- Every immediate is sign-extended from its top bit to XLEN. This includes U-type, whose bit 31 extends into [63:32] when XLEN=64. Shift-immediate funct7 bits are not stripped.
- Storage is a circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready. A push while full is impossible; when full, a simultaneous pop does not admit a new entry that cycle.
- out_valid = (count != 0). While out_valid=0, out_instr, out_imm, out_fmt and out_illegal are driven to 0.
- illegal_cnt increments by 1 on each push of an illegal instruction. It holds at 0xFFFF and is never decremented by pops.

## Timing
- Reset values: count=0, pointers=0, in_ready=1, out_valid=0, all data outputs=0, illegal_cnt=0. The buffer contents are don't-care.
- Latency: an instruction pushed in cycle N appears on the outputs in cycle N+1 if the buffer was empty. Otherwise it appears behind older entries, with order strictly preserved.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Empty buffer with simultaneous push: no bypass. out_valid rises the next cycle.
- When count=DEPTH, in_ready is low that cycle. It rises the cycle after the first pop.
- rst mid-operation drops all buffered entries and clears illegal_cnt. Handshakes in the reset cycle are ignored. Outputs show reset values from the next cycle.
- Outputs hold stable while out_valid=1 && out_ready=0.

## Test plan
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- Back-to-back pushes with out_ready=1:
  - 0x00112623 -> imm 0x0000000C, fmt 2
  - 0xFE000EE3 -> imm 0xFFFFFFFC, fmt 3
  - 0x123450B7 -> imm 0x12345000, fmt 4
  - 0x001000EF -> imm 0x00000800, fmt 5
  - Required: one result per cycle, in order.
- Push 0x0000007F twice -> out_fmt=7, out_illegal=1, out_imm=0, illegal_cnt=2. Preload the counter at 0xFFFF (force), push one more illegal -> counter stays 0xFFFF.
- DEPTH=2, out_ready=0, present three instructions -> two accepted, in_ready=0 with the third held. Raise out_ready -> all three emerge in order, in_ready returns high one cycle after the first pop.
- Two entries buffered, assert rst for one cycle -> next cycle out_valid=0, in_ready=1, illegal_cnt=0. The next push appears alone at N+1.
- XLEN=64, push 0xFFF00093 -> out_imm=0xFFFFFFFFFFFFFFFF. Push 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000.
